// File: rtl/add_order_fifo.sv
// add_order_fifo
//   Buffers decoded Add Order messages between add_order_decoder and the next
//   consumer. Each accepted order is tagged with a 16-bit sequence number.
//   Storage is a ring of DEPTH register cells. The head entry is presented
//   first-word-fall-through: out_valid and out_* come only from registers, so
//   no input reaches an output in the same cycle.
//   Orders that arrive while the FIFO is full and no pop happens are dropped.
//   Dropped orders set a sticky overflow flag and increment a saturating drop
//   counter.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   add_order_decoded          one-cycle strobe qualifying the field inputs
//   order_ref/buy_sell/shares/
//   stock_symbol/price         decoded order fields
//   out_valid/out_ready        head-entry handshake
//   out_*                      head-entry fields, out_seq = its sequence tag
//   fill_level                 entries held, 0..DEPTH
//   overflow, drop_count       sticky drop flag, saturating drop counter
//   clear_overflow             clears overflow and drop_count

// One storage slot. Reset to zero so the head bus reads 0 after reset.
module add_order_fifo_cell #(
  parameter int W = 209
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    data_q <= '0;
    else if (we_i) data_q <= d_i;
  end

  assign q_o = data_q;
endmodule

module add_order_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              add_order_decoded,
  input  logic [63:0]       order_ref,
  input  logic              buy_sell,
  input  logic [31:0]       shares,
  input  logic [63:0]       stock_symbol,
  input  logic [31:0]       price,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       out_order_ref,
  output logic              out_buy_sell,
  output logic [31:0]       out_shares,
  output logic [63:0]       out_stock_symbol,
  output logic [31:0]       out_price,
  output logic [15:0]       out_seq,
  output logic [ADDR_W:0]   fill_level,
  output logic              overflow,
  output logic [15:0]       drop_count,
  input  logic              clear_overflow
);

  typedef struct packed {
    logic [15:0] seq;
    logic [63:0] order_ref;
    logic        buy_sell;
    logic [31:0] shares;
    logic [63:0] stock_symbol;
    logic [31:0] price;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  // State
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   cnt_q,    cnt_d;
  logic [15:0]       seq_q,    seq_d;
  logic              ovf_q,    ovf_d;
  logic [15:0]       drop_q,   drop_d;

  // Handshake decode
  logic   valid, full, pop, push, drop;
  entry_t wr_entry, head;

  logic [DEPTH-1:0]              cell_we;
  logic [DEPTH-1:0][ENTRY_W-1:0] cell_q;

  assign valid = (cnt_q != '0);
  assign full  = (cnt_q == CNT_FULL);
  assign pop   = valid && out_ready;
  // A full FIFO still takes a new order when the head leaves in the same cycle.
  assign push  = add_order_decoded && (!full || pop);
  assign drop  = add_order_decoded && full && !pop;

  assign wr_entry = '{seq:          seq_q,
                      order_ref:    order_ref,
                      buy_sell:     buy_sell,
                      shares:       shares,
                      stock_symbol: stock_symbol,
                      price:        price};

  always_comb begin
    cell_we = '0;
    if (push) cell_we[wr_ptr_q] = 1'b1;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_cell
    add_order_fifo_cell #(.W(ENTRY_W)) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .we_i  (cell_we[g]),
      .d_i   (wr_entry),
      .q_o   (cell_q[g])
    );
  end

  // Next-state
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    // Dropped orders do not use up a sequence number.
    seq_d    = push ? seq_q + 16'd1      : seq_q;

    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase

    // Clear is applied first, so a drop in the same cycle leaves count = 1.
    ovf_d  = clear_overflow ? 1'b0  : ovf_q;
    drop_d = clear_overflow ? 16'd0 : drop_q;
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_d != 16'hFFFF) drop_d = drop_d + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      seq_q    <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      seq_q    <= seq_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  // Head presentation. All of these signals come only from registers.
  assign head             = cell_q[rd_ptr_q];
  assign out_valid        = valid;
  assign out_order_ref    = head.order_ref;
  assign out_buy_sell     = head.buy_sell;
  assign out_shares       = head.shares;
  assign out_stock_symbol = head.stock_symbol;
  assign out_price        = head.price;
  assign out_seq          = head.seq;
  assign fill_level       = cnt_q;
  assign overflow         = ovf_q;
  assign drop_count       = drop_q;

endmodule

// File: tb/tb_add_order_fifo.sv
module tb_add_order_fifo;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        add_order_decoded, buy_sell, out_ready, clear_overflow;
  logic [63:0] order_ref, stock_symbol;
  logic [31:0] shares, price;
  logic        out_valid, out_buy_sell, overflow;
  logic [63:0] out_order_ref, out_stock_symbol;
  logic [31:0] out_shares, out_price;
  logic [15:0] out_seq, drop_count;
  logic [4:0]  fill_level;

  always #5 clk = ~clk;

  add_order_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .add_order_decoded(add_order_decoded),
    .order_ref(order_ref), .buy_sell(buy_sell), .shares(shares),
    .stock_symbol(stock_symbol), .price(price), .out_valid(out_valid),
    .out_ready(out_ready), .out_order_ref(out_order_ref),
    .out_buy_sell(out_buy_sell), .out_shares(out_shares),
    .out_stock_symbol(out_stock_symbol), .out_price(out_price),
    .out_seq(out_seq), .fill_level(fill_level), .overflow(overflow),
    .drop_count(drop_count), .clear_overflow(clear_overflow)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    add_order_decoded = 1'b0; out_ready = 1'b0; clear_overflow = 1'b0;
    order_ref = '0; buy_sell = 1'b0; shares = '0; stock_symbol = '0; price = '0;
  endtask

  task automatic do_reset;
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
  endtask

  // Present one order for a single cycle.
  task automatic push_ord(input logic [63:0] r, input logic [31:0] sh);
    add_order_decoded = 1'b1; order_ref = r; shares = sh;
    buy_sell = r[0]; stock_symbol = ~r; price = sh + 32'd7;
    tick();
    add_order_decoded = 1'b0;
  endtask

  // Scripted vector table
  typedef struct packed {
    logic        s, r, c;
    logic [63:0] rf;
    logic        ev;
    logic [4:0]  ef;
    logic [63:0] eh;
    logic [15:0] es;
    logic        eo;
    logic [15:0] ed;
  } vec_t;
  vec_t tbl [10];

  // Reference model: queue of accepted orders, plus counters
  typedef struct {
    logic [15:0] seq;
    logic [63:0] r;
    logic        bs;
    logic [31:0] sh;
    logic [63:0] sym;
    logic [31:0] pr;
  } ord_t;
  ord_t        mq[$];
  logic [15:0] mseq, mdrop;
  logic        movf;

  task automatic cmp_model(input string tag);
    chk({tag, ".valid"}, 64'(out_valid), 64'(mq.size() != 0));
    chk({tag, ".fill"}, 64'(fill_level), 64'(mq.size()));
    chk({tag, ".ovf"}, 64'(overflow), 64'(movf));
    chk({tag, ".drop"}, 64'(drop_count), 64'(mdrop));
    if (mq.size() != 0) begin
      chk({tag, ".seq"}, 64'(out_seq), 64'(mq[0].seq));
      chk({tag, ".ref"}, out_order_ref, mq[0].r);
      chk({tag, ".bs"}, 64'(out_buy_sell), 64'(mq[0].bs));
      chk({tag, ".sh"}, 64'(out_shares), 64'(mq[0].sh));
      chk({tag, ".sym"}, out_stock_symbol, mq[0].sym);
      chk({tag, ".pr"}, 64'(out_price), 64'(mq[0].pr));
    end
  endtask

  // Advance the model by one clock, using the current inputs.
  task automatic model_step;
    logic full, pop;
    full = (mq.size() == DEPTH);
    pop  = (mq.size() != 0) && out_ready;
    if (pop) void'(mq.pop_front());
    if (clear_overflow) begin movf = 1'b0; mdrop = 16'd0; end
    if (add_order_decoded) begin
      if (!full || pop) begin
        mq.push_back('{mseq, order_ref, buy_sell, shares, stock_symbol, price});
        mseq = mseq + 16'd1;
      end else begin
        movf = 1'b1;
        if (mdrop != 16'hFFFF) mdrop = mdrop + 16'd1;
      end
    end
  endtask

  initial begin
    //            s  r  c  ref                     ev f  head                    seq  ovf drop
    tbl[0] = '{1'b1,1'b1,1'b0,64'h1122334455667788,1'b1,5'd1,64'h1122334455667788,16'd0,1'b0,16'd0};
    tbl[1] = '{1'b0,1'b1,1'b0,64'h0,               1'b0,5'd0,64'h0,               16'd0,1'b0,16'd0};
    tbl[2] = '{1'b1,1'b0,1'b0,64'hA1,              1'b1,5'd1,64'hA1,              16'd1,1'b0,16'd0};
    tbl[3] = '{1'b1,1'b0,1'b0,64'hA2,              1'b1,5'd2,64'hA1,              16'd1,1'b0,16'd0};
    tbl[4] = '{1'b0,1'b0,1'b0,64'h0,               1'b1,5'd2,64'hA1,              16'd1,1'b0,16'd0};
    tbl[5] = '{1'b1,1'b1,1'b0,64'hA3,              1'b1,5'd2,64'hA2,              16'd2,1'b0,16'd0};
    tbl[6] = '{1'b0,1'b1,1'b0,64'h0,               1'b1,5'd1,64'hA3,              16'd3,1'b0,16'd0};
    tbl[7] = '{1'b0,1'b1,1'b0,64'h0,               1'b0,5'd0,64'h0,               16'd0,1'b0,16'd0};
    tbl[8] = '{1'b0,1'b1,1'b0,64'h0,               1'b0,5'd0,64'h0,               16'd0,1'b0,16'd0};
    tbl[9] = '{1'b0,1'b0,1'b1,64'h0,               1'b0,5'd0,64'h0,               16'd0,1'b0,16'd0};

    // Reset state
    do_reset();
    chk("rst.valid", 64'(out_valid), 64'd0);
    chk("rst.fill", 64'(fill_level), 64'd0);
    chk("rst.ovf", 64'(overflow), 64'd0);
    chk("rst.drop", 64'(drop_count), 64'd0);
    chk("rst.seq", 64'(out_seq), 64'd0);
    chk("rst.ref", out_order_ref, 64'd0);
    chk("rst.price", 64'(out_price), 64'd0);

    // Single order, latency 1, no bypass
    add_order_decoded = 1'b1; out_ready = 1'b1;
    order_ref = 64'h1122334455667788; buy_sell = 1'b1; shares = 32'd100;
    stock_symbol = 64'h4141504C20202020; price = 32'd1500000;
    #1 chk("one.nobypass", 64'(out_valid), 64'd0);
    tick();
    idle(); out_ready = 1'b1;
    chk("one.valid", 64'(out_valid), 64'd1);
    chk("one.fill", 64'(fill_level), 64'd1);
    chk("one.ref", out_order_ref, 64'h1122334455667788);
    chk("one.bs", 64'(out_buy_sell), 64'd1);
    chk("one.sh", 64'(out_shares), 64'd100);
    chk("one.sym", out_stock_symbol, 64'h4141504C20202020);
    chk("one.pr", 64'(out_price), 64'd1500000);
    chk("one.seq", 64'(out_seq), 64'd0);
    tick();
    chk("one.fill0", 64'(fill_level), 64'd0);
    chk("one.valid0", 64'(out_valid), 64'd0);

    // Table-driven sequence
    do_reset();
    for (int i = 0; i < 10; i++) begin
      add_order_decoded = tbl[i].s; out_ready = tbl[i].r; clear_overflow = tbl[i].c;
      order_ref = tbl[i].rf;
      tick();
      chk($sformatf("tbl%0d.valid", i), 64'(out_valid), 64'(tbl[i].ev));
      chk($sformatf("tbl%0d.fill", i), 64'(fill_level), 64'(tbl[i].ef));
      chk($sformatf("tbl%0d.ovf", i), 64'(overflow), 64'(tbl[i].eo));
      chk($sformatf("tbl%0d.drop", i), 64'(drop_count), 64'(tbl[i].ed));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d.ref", i), out_order_ref, tbl[i].eh);
        chk($sformatf("tbl%0d.seq", i), 64'(out_seq), 64'(tbl[i].es));
      end
    end
    idle();

    // Fill, overflow, then push while popping a full FIFO
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      push_ord(64'h1000 + 64'(i), 32'(i));
      chk($sformatf("full.fill%0d", i), 64'(fill_level), 64'(i + 1));
    end
    push_ord(64'hDEAD, 32'd99);
    chk("full.fill16", 64'(fill_level), 64'd16);
    chk("full.ovf", 64'(overflow), 64'd1);
    chk("full.drop", 64'(drop_count), 64'd1);
    chk("full.headseq", 64'(out_seq), 64'd0);
    chk("full.headref", out_order_ref, 64'h1000);
    out_ready = 1'b1;
    push_ord(64'hBEEF, 32'd55);
    chk("pp.fill", 64'(fill_level), 64'd16);
    chk("pp.headseq", 64'(out_seq), 64'd1);
    for (int k = 0; k < DEPTH; k++) begin
      chk($sformatf("drain%0d.valid", k), 64'(out_valid), 64'd1);
      chk($sformatf("drain%0d.seq", k), 64'(out_seq), (k < 15) ? 64'(k + 1) : 64'd16);
      chk($sformatf("drain%0d.ref", k), out_order_ref, (k < 15) ? 64'h1001 + 64'(k) : 64'hBEEF);
      chk($sformatf("drain%0d.sh", k), 64'(out_shares), (k < 15) ? 64'(k + 1) : 64'd55);
      tick();
    end
    chk("drain.empty", 64'(out_valid), 64'd0);
    chk("drain.fill", 64'(fill_level), 64'd0);
    idle();

    // Clear overflow, and clear coincident with a drop
    do_reset();
    for (int i = 0; i < DEPTH + 5; i++) push_ord(64'h2000 + 64'(i), 32'(i));
    chk("clr.pre.ovf", 64'(overflow), 64'd1);
    chk("clr.pre.drop", 64'(drop_count), 64'd5);
    clear_overflow = 1'b1;
    tick();
    chk("clr.ovf", 64'(overflow), 64'd0);
    chk("clr.drop", 64'(drop_count), 64'd0);
    add_order_decoded = 1'b1;
    tick();
    chk("clrdrop.ovf", 64'(overflow), 64'd1);
    chk("clrdrop.drop", 64'(drop_count), 64'd1);
    chk("clrdrop.fill", 64'(fill_level), 64'd16);
    idle();

    // Reset in mid-operation
    do_reset();
    for (int i = 0; i < 7; i++) push_ord(64'h3000 + 64'(i), 32'(i));
    chk("mid.fill7", 64'(fill_level), 64'd7);
    add_order_decoded = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("mid.valid", 64'(out_valid), 64'd0);
    chk("mid.fill", 64'(fill_level), 64'd0);
    chk("mid.ovf", 64'(overflow), 64'd0);
    tick();
    chk("mid.ignored", 64'(fill_level), 64'd0);
    add_order_decoded = 1'b0;
    rst_n = 1'b1;
    tick();
    push_ord(64'h77, 32'd7);
    chk("mid.after.valid", 64'(out_valid), 64'd1);
    chk("mid.after.seq", 64'(out_seq), 64'd0);
    chk("mid.after.ref", out_order_ref, 64'h77);
    idle();

    // Randomised traffic with back-pressure against the queue model
    do_reset();
    mq.delete(); mseq = 16'd0; mdrop = 16'd0; movf = 1'b0;
    begin
      int strobes = 0, cycles = 0;
      while (strobes < 200 && cycles < 3000) begin
        add_order_decoded = ($urandom_range(0, 99) < 60);
        if (add_order_decoded) begin
          strobes++;
          order_ref = {$urandom, $urandom}; buy_sell = 1'($urandom);
          shares = $urandom; stock_symbol = {$urandom, $urandom}; price = $urandom;
        end
        out_ready = ($urandom_range(0, 99) < 45);
        clear_overflow = ($urandom_range(0, 39) == 0);
        cmp_model($sformatf("rnd%0d", cycles));
        model_step();
        tick();
        cycles++;
      end
      chk("rnd.budget", 64'(strobes), 64'd200);
      idle(); out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
        cmp_model($sformatf("rdrain%0d", i));
        model_step();
        tick();
      end
      chk("rnd.empty", 64'(fill_level), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
